// File: rtl/pipe_flow_ctrl.sv
// pipe_flow_ctrl: flow-control wrapper around a fixed-latency, clock-enabled
// shift_reg datapath. It tracks which pipeline stages hold valid items, stalls
// the pipeline only when a valid head item cannot be stored, and buffers
// pipeline output in a small FIFO with a valid/ready handshake downstream.
module pipe_flow_ctrl #(
    parameter int WIDTH      = 8,
    parameter int LATENCY    = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             pipe_en,
    input  logic [WIDTH-1:0] pipe_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [LATENCY-1:0] vbit;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic [WIDTH-1:0]   mem [FIFO_DEPTH];

    logic full;
    logic push;
    logic pop;

    // Handshake decode: stall only when a valid head item has nowhere to go.
    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        out_valid = (count != '0);
        pop       = out_valid & out_ready;
        full      = (count == CNT_W'(FIFO_DEPTH));
        pipe_en   = !(vbit[0] & full & !pop);
        push      = pipe_en & vbit[0];
        in_ready  = pipe_en;
        out_data  = out_valid ? mem[rd_ptr] : '0;
    end

    // Valid bits shift toward stage 0 in lockstep with the enabled pipeline.
    generate
        if (LATENCY > 1) begin : g_vbit_multi
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vbit <= '0;
                end else if (pipe_en) begin
                    vbit <= {in_valid, vbit[LATENCY-1:1]};
                end
            end
        end else begin : g_vbit_single
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vbit <= '0;
                end else if (pipe_en) begin
                    vbit <= in_valid;
                end
            end
        end
    endgenerate

    // FIFO storage: written on push, read combinationally at the head.
    // NOTE: the data array is not reset; out_valid and the out_data gating make stale entries invisible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= pipe_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at a power-of-two depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// tb_pipe_flow_ctrl: drives pipe_flow_ctrl wrapped around a behavioural
// shift_reg pipeline and compares it each cycle against a slot/queue model.
module tb_pipe_flow_ctrl;

    localparam int W  = 8;
    localparam int L  = 3;
    localparam int FD = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         pipe_en;
    logic [W-1:0] pipe_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [W-1:0] in_data;

    int n_tests = 0;
    int n_fail  = 0;

    // External datapath: shift_reg stages enabled by pipe_en, head is stage 0.
    logic [W-1:0] hp [L];
    assign pipe_data = hp[0];

    always @(posedge clk) begin
        if (pipe_en) begin
            for (int i = 0; i < L - 1; i++) hp[i] <= hp[i+1];
            hp[L-1] <= in_data;
        end
    end

    always #5 clk = ~clk;

    pipe_flow_ctrl #(.WIDTH(W), .LATENCY(L), .FIFO_DEPTH(FD)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pipe_en   (pipe_en),
        .pipe_data (pipe_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    // Reference model: pipeline slots, FIFO contents and accepted-item scoreboard.
    bit           mv [L];
    logic [W-1:0] md [L];
    logic [W-1:0] fq [$];
    logic [W-1:0] sb [$];
    int           n_acc;
    int           n_pop;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < L; i++) begin
            mv[i] = 1'b0;
            md[i] = '0;
        end
        fq.delete();
        sb.delete();
    endtask

    // One clock cycle: drive, check combinational outputs, then advance the model.
    task automatic cycle(input bit iv, input logic [W-1:0] id, input bit ordy,
                         output bit acc, output bit ov, output bit en);
        bit exp_pop;
        bit exp_en;
        @(negedge clk);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        #1;
        exp_pop = (fq.size() != 0) && ordy;
        exp_en  = !(mv[0] && (fq.size() == FD) && !exp_pop);
        check("pipe_en", 32'(pipe_en), 32'(exp_en));
        check("in_ready", 32'(in_ready), 32'(exp_en));
        check("out_valid", 32'(out_valid), 32'(fq.size() != 0));
        if (fq.size() != 0) check("out_data", 32'(out_data), 32'(fq[0]));
        if (out_valid === 1'b1 && ordy) begin
            if (sb.size() == 0) begin
                check("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                check("order", 32'(out_data), 32'(sb.pop_front()));
            end
            n_pop++;
        end
        ov = (out_valid === 1'b1);
        en = (pipe_en === 1'b1);
        @(posedge clk);
        if (exp_pop) void'(fq.pop_front());
        if (exp_en && mv[0]) fq.push_back(md[0]);
        if (exp_en) begin
            for (int i = 0; i < L - 1; i++) begin
                mv[i] = mv[i+1];
                md[i] = md[i+1];
            end
            mv[L-1] = iv;
            md[L-1] = id;
            if (iv) begin
                sb.push_back(id);
                n_acc++;
            end
        end
        acc = exp_en && iv;
    endtask

    initial begin
        bit acc, ov, en;
        int first_ov;
        int seen;
        int idx;
        logic [W-1:0] sparse [4];
        bit           sparse_v [4];

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        n_acc = 0; n_pop = 0;
        for (int i = 0; i < L; i++) hp[i] = '0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_pipe_en", 32'(pipe_en), 32'd1);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // 1: streaming with out_ready held high.
        first_ov = -1;
        n_pop = 0;
        for (int k = 0; k < 16; k++) begin
            cycle(k < 8, W'(k + 1), 1'b1, acc, ov, en);
            if (ov && first_ov < 0) first_ov = k;
        end
        check("t1_first_out", 32'(first_ov), 32'd4);
        check("t1_pops", 32'(n_pop), 32'd8);

        // 2: downstream blocked, upstream holds the stalled item.
        idx = 0;
        for (int k = 0; k < 12; k++) begin
            cycle(1'b1, W'(8'h10 + idx), 1'b0, acc, ov, en);
            if (acc) idx++;
        end
        check("t2_accepted_before_stall", 32'(idx), 32'd7);
        check("t2_stalled", 32'(en), 32'd0);
        for (int k = 0; k < 40; k++) begin
            cycle(idx < 16, W'(8'h10 + idx), 1'b1, acc, ov, en);
            if (acc) idx++;
        end
        check("t2_all_accepted", 32'(idx), 32'd16);
        check("t2_drained", 32'(sb.size()), 32'd0);

        // 3: fill FIFO, then a sparse burst compresses its bubbles.
        for (int k = 0; k < 7; k++) cycle(k < 4, W'(8'h30 + k), 1'b0, acc, ov, en);
        check("t3_full_valid", 32'(ov), 32'd1);
        sparse[0] = 8'hA0; sparse_v[0] = 1'b1;
        sparse[1] = 8'h00; sparse_v[1] = 1'b0;
        sparse[2] = 8'h00; sparse_v[2] = 1'b0;
        sparse[3] = 8'hA1; sparse_v[3] = 1'b1;
        idx = 0;
        for (int k = 0; k < 8; k++) begin
            cycle(sparse_v[idx], sparse[idx], 1'b0, acc, ov, en);
            if (en && idx < 3) idx++;
        end
        check("t3_sparse_pos", 32'(idx), 32'd3);
        check("t3_head_stall", 32'(en), 32'd0);

        // 4: one-cycle out_ready pulse with a valid head: pop and push together.
        cycle(1'b1, 8'hA1, 1'b1, acc, ov, en);
        check("t4_pop_push_en", 32'(en), 32'd1);
        check("t4_a1_accepted", 32'(acc), 32'd1);
        cycle(1'b0, 8'h00, 1'b0, acc, ov, en);
        check("t4_still_full", 32'(ov), 32'd1);
        for (int k = 0; k < 20; k++) cycle(1'b0, 8'h00, 1'b1, acc, ov, en);
        check("t4_drained", 32'(sb.size()), 32'd0);

        // 5: asynchronous reset with items buffered and in flight.
        for (int k = 0; k < 5; k++) cycle(1'b1, W'(8'h50 + k), 1'b0, acc, ov, en);
        check("t5_pre_rst_valid", 32'(ov), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("t5_rst_out_valid", 32'(out_valid), 32'd0);
        check("t5_rst_pipe_en", 32'(pipe_en), 32'd1);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            cycle(1'b0, 8'h00, 1'b1, acc, ov, en);
            if (ov) seen++;
        end
        check("t5_no_stale", 32'(seen), 32'd0);

        // 6: random traffic against the model.
        n_acc = 0;
        n_pop = 0;
        for (int k = 0; k < 2000; k++) begin
            cycle(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)), acc, ov, en);
        end
        for (int k = 0; k < 20; k++) cycle(1'b0, 8'h00, 1'b1, acc, ov, en);
        check("t6_drained", 32'(sb.size()), 32'd0);
        check("t6_acc_eq_pop", 32'(n_pop), 32'(n_acc));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_flow_ctrl.md
Name: pipe_flow_ctrl

Overview:
- Flow-control stage that wraps a fixed-latency, clock-enabled datapath pipeline built from shift_reg instances.
- Drives the pipeline clock enable and tracks which stages hold valid data.
- Captures pipeline output into a small output FIFO, presenting valid/ready handshakes both upstream and downstream.
- Sits between upstream pixel/vertex producers and downstream consumers in the GPU datapath.
- The datapath data itself bypasses this block on the input side and enters the external pipeline directly.

Parameters:
- WIDTH, 8: data width of the pipeline output and out_data.
- LATENCY, 3: number of enabled clock edges from pipeline input to pipeline output. Must be ≥1 and must match the DEPTH of the wrapped shift_reg pipeline.
- FIFO_DEPTH, 4: output FIFO entries. Must be ≥2 and a power of two.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream has a data item on the pipeline input this cycle.
- in_ready  out  1  item accepted this cycle; equals pipe_en.
- pipe_en  out  1  clock enable to every shift_reg stage of the wrapped pipeline.
- pipe_data  in  WIDTH  pipeline output (stage 0 of the wrapped pipeline).
- out_valid  out  1  out_data holds a valid item.
- out_ready  in  1  downstream accepts out_data this cycle.
- out_data  out  WIDTH  FIFO head.

Behaviour:
- Reset (async, active-high):
  - valid-tracking bits vbit[LATENCY-1:0] = 0.
  - FIFO read pointer, write pointer and count = 0.
  - Outputs: out_valid = 0, out_data = 0, pipe_en = 1, in_ready = 1.
  - Reset mid-operation discards all in-flight and buffered items. No push occurs on the first edge after reset release.
- Valid tracking mirrors shift_reg ordering:
  - On a clk edge with pipe_en = 1: vbit[i-1] <= vbit[i] for i = 1..LATENCY-1, and vbit[LATENCY-1] <= in_valid.
  - With pipe_en = 0, vbit holds.
  - vbit[0] = 1 means pipe_data is valid this cycle.
- pop = out_valid & out_ready.
- full = (count == FIFO_DEPTH).
- pipe_en = !(vbit[0] & full & !pop). This is combinational and includes the out_ready → pipe_en path.
  - The pipeline advances freely when its head is a bubble, even if the FIFO is full. Bubbles are never pushed.
- push = pipe_en & vbit[0]. On push, pipe_data is written at the write pointer.
- Simultaneous push and pop: both occur and count is unchanged. This is legal even when full.
- in_ready = pipe_en. An upstream transfer happens when in_valid & in_ready.
  - Upstream must hold the item while in_ready = 0, because the pipeline is frozen.
- Latency: an item accepted at edge N with no stalls is pushed at edge N+LATENCY. out_valid rises in the following cycle. Minimum in→out is LATENCY+1 cycles.
- out_valid = (count != 0). out_data = FIFO head.
  - Both are registered-state driven; there is no combinational path from pipe_data.
- Pointers wrap modulo FIFO_DEPTH.
- count is ($clog2(FIFO_DEPTH)+1) bits wide and never exceeds FIFO_DEPTH or underflows.
- Throughput: one item per cycle when out_ready is held at 1.
- Stall: while stalled, every bit of state in the block holds, and the wrapped pipeline holds because pipe_en = 0.

Test Plan:
- Use WIDTH=8, LATENCY=3, FIFO_DEPTH=4 throughout.
1. Reset, then hold out_ready=1 and stream in_valid=1 with items 0x01..0x08 on consecutive cycles → out_valid first rises 4 cycles after the first accept. Outputs are 0x01..0x08 in order, back-to-back, and pipe_en stays 1 throughout.
2. Hold out_ready=0 and stream 0x10..0x1F → the FIFO fills with 0x10..0x13 and the pipeline then holds 0x14..0x16. pipe_en and in_ready drop to 0 and stay 0. Upstream 0x17 is held. Releasing out_ready drains 0x10..0x1F with no loss or duplication.
3. Feed a sparse input (0xA0, bubble, bubble, 0xA1) with the FIFO full and out_ready=0 → pipe_en stays 1 while vbit[0]=0, so bubbles compress. It drops only when 0xA0 reaches the head. count stays 4.
4. With the FIFO full and vbit[0]=1, pulse out_ready=1 for one cycle → pop and push occur on the same edge, count stays 4, and pipe_en=1 during that cycle.
5. Assert rst mid-stream with 2 items in the FIFO and 3 in flight → out_valid=0 immediately (async) and count=0. After release, no stale item emerges within 10 cycles.
6. Run random in_valid/out_ready (50% each) for 2000 cycles against a scoreboard model of the shift_reg pipeline → output order matches input order exactly. No item is lost or duplicated, and count stays ≤4.
